config_chain_loader: RTL
========================

CONFIG_CHAIN_LOADER -- requirements
Module: config_chain_loader

Interface
REQ-001 SHALL have parameter CHAIN_LEN, default 1024: number of scan flip-flops in the configuration chain (>= 1).
REQ-002 SHALL have parameter WORD_W, default 8: width of the bitstream word (>= 2).
REQ-003 SHALL define CNT_W = clog2(CHAIN_LEN+1), a derived local value, not overridable.
REQ-004 CK  input  1  sole clock; all state updates on its rising edge.
REQ-005 RST_N  input  1  reset, asynchronous and active-low; assertion clears all state immediately, deassertion is sampled on CK.
REQ-006 START  input  1  level-sampled request to begin a load; acted on only in IDLE or DONE.
REQ-007 ABORT  input  1  synchronous abort of a load in progress.
REQ-008 WORD_DATA  input  WORD_W  bitstream word; MSB is shifted first.
REQ-009 WORD_VALID  input  1  WORD_DATA is valid.
REQ-010 WORD_READY  output  1  loader accepts WORD_DATA this cycle.
REQ-011 CCFF_HEAD  output  1  serial data to the chain head (SI of the first scan flop).
REQ-012 CCFF_SE  output  1  chain shift enable (SE of every scan flop); the chain shifts exactly on cycles where this is 1.
REQ-013 BUSY  output  1  a load is in progress.
REQ-014 DONE  output  1  all CHAIN_LEN bits have been shifted.
REQ-015 ISOL_N  output  1  I/O isolation release (drives IO_ISOL_N); 1 only in DONE.
REQ-016 BIT_COUNT  output  CNT_W  number of bits shifted in the current or last load.

Function
REQ-017 SHALL implement four states: IDLE, FETCH, SHIFT, DONE; all outputs SHALL be registered.
REQ-018 IDLE: BUSY=0, DONE=0, ISOL_N=0, SE=0; START=1 -> FETCH, BIT_COUNT cleared to 0.
REQ-019 FETCH: WORD_READY=1, SE=0 (chain holds), BUSY=1; on WORD_VALID&&WORD_READY, load WORD_DATA into the shift register -> SHIFT.
REQ-020 SHIFT: SE=1 and CCFF_HEAD = current MSB of the shift register every cycle; register shifts left by one and BIT_COUNT increments by one each cycle.
REQ-021 Handshake-to-first-bit latency SHALL be 1 cycle: a word accepted at edge N gives SE=1 with its MSB on CCFF_HEAD in the cycle following edge N.
REQ-022 After WORD_W bits of a word with BIT_COUNT < CHAIN_LEN -> FETCH; sustained throughput SHALL be WORD_W bits per WORD_W+1 cycles.
REQ-023 When BIT_COUNT reaches CHAIN_LEN -> DONE immediately, even mid-word; remaining low-order bits of that word SHALL be discarded.
REQ-024 Exactly CHAIN_LEN cycles SHALL have SE=1 per completed load; total words consumed SHALL be ceil(CHAIN_LEN/WORD_W).
REQ-025 WORD_VALID low in FETCH SHALL stall with SE=0 indefinitely and no timeout; WORD_DATA outside FETCH SHALL be ignored and WORD_READY SHALL stay 0.
REQ-026 DONE: DONE=1, ISOL_N=1, BUSY=0, SE=0, and BIT_COUNT holds CHAIN_LEN; START=1 -> FETCH with DONE=0 and ISOL_N=0 on the next cycle, BIT_COUNT cleared.
REQ-027 START during FETCH or SHIFT SHALL be ignored.
REQ-028 ABORT=1 in FETCH or SHIFT -> IDLE next cycle with SE=0, ISOL_N=0, and BIT_COUNT holding its value; ABORT SHALL take priority over a same-cycle handshake or the final shift; ABORT in IDLE or DONE SHALL be ignored.
REQ-029 CCFF_HEAD SHALL be 0 whenever SE=0.

Reset
REQ-030 RST_N=0 SHALL force, asynchronously, state=IDLE, WORD_READY=0, CCFF_HEAD=0, CCFF_SE=0, BUSY=0, DONE=0, ISOL_N=0, BIT_COUNT=0, and shift register=0.
REQ-031 Reset mid-SHIFT SHALL drop SE within the reset assertion, with no further chain shift; the next load SHALL need a new START.

Verification (CHAIN_LEN=10, WORD_W=8)
REQ-032 Basic load: START, then words 0xA5, 0xC0 with VALID held -> HEAD sequence 1,0,1,0,0,1,0,1 | 1,1 on SE=1 cycles; one SE=0 gap between words; DONE=1, ISOL_N=1, BIT_COUNT=10; exactly 2 handshakes.
REQ-033 Stall: VALID low 5 cycles before the second word -> SE=0 and HEAD=0 for 5 extra cycles; total SE=1 cycles still 10.
REQ-034 Abort: ABORT pulse after the 4th shifted bit -> IDLE next cycle, BIT_COUNT=4, ISOL_N=0, and no further SE.
REQ-035 Reset mid-shift: RST_N low at bit 6 -> all outputs 0 without waiting for CK, and START is needed to resume.
REQ-036 Reload: START in DONE -> ISOL_N 0 next cycle, BIT_COUNT 0; a second load completes identically, and START while BUSY has no effect.

Source files
------------

// File: rtl/config_chain_loader_if.sv
// Word-stream and chain-control bundle for config_chain_loader.
// The slave side is the loader; the master side is whatever feeds it bitstream words.
interface config_chain_loader_if #(
    parameter int CHAIN_LEN = 1024,
    parameter int WORD_W    = 8
);
    localparam int CNT_W = $clog2(CHAIN_LEN + 1);

    logic              start;
    logic              abort;
    logic [WORD_W-1:0] word_data;
    logic              word_valid;
    logic              word_ready;
    logic              ccff_head;
    logic              ccff_se;
    logic              busy;
    logic              done;
    logic              isol_n;
    logic [CNT_W-1:0]  bit_count;

    modport master (
        output start, abort, word_data, word_valid,
        input  word_ready, ccff_head, ccff_se, busy, done, isol_n, bit_count
    );

    modport slave (
        input  start, abort, word_data, word_valid,
        output word_ready, ccff_head, ccff_se, busy, done, isol_n, bit_count
    );
endinterface

// File: rtl/config_chain_loader.sv
// Serialises a word stream MSB-first into a scan configuration chain of CHAIN_LEN flops,
// then releases I/O isolation once the whole chain has been loaded.
module config_chain_loader #(
    parameter int CHAIN_LEN = 1024,
    parameter int WORD_W    = 8
) (
    input  logic                 ck,
    input  logic                 rst_n,
    config_chain_loader_if.slave bus
);
    localparam int CNT_W = $clog2(CHAIN_LEN + 1);
    localparam int BIT_W = $clog2(WORD_W);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_SHIFT,
        ST_DONE
    } state_t;

    state_t            state;
    logic [WORD_W-1:0] shreg;
    logic [BIT_W-1:0]  bits_left;
    logic [CNT_W-1:0]  bit_count;
    logic              word_ready;
    logic              ccff_head;
    logic              ccff_se;
    logic              busy;
    logic              done;
    logic              isol_n;

    // The bit on the head during this SE cycle is the last one the chain needs.
    logic last_chain_bit;
    assign last_chain_bit = (bit_count == CNT_W'(CHAIN_LEN - 1));

    assign bus.word_ready = word_ready;
    assign bus.ccff_head  = ccff_head;
    assign bus.ccff_se    = ccff_se;
    assign bus.busy       = busy;
    assign bus.done       = done;
    assign bus.isol_n     = isol_n;
    assign bus.bit_count  = bit_count;

    // NOTE: every register here uses <= so all of them update from the same pre-edge
    // values; a blocking = would let a later line see an already-updated value.
    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            // NOTE: the shift register is reset too, so no stale word can ever reach
            // the chain head after an interrupted load.
            shreg      <= '0;
            bits_left  <= '0;
            bit_count  <= '0;
            word_ready <= 1'b0;
            ccff_head  <= 1'b0;
            ccff_se    <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            isol_n     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (bus.start) begin
                        state      <= ST_FETCH;
                        bit_count  <= '0;
                        word_ready <= 1'b1;
                        busy       <= 1'b1;
                        done       <= 1'b0;
                        isol_n     <= 1'b0;
                    end
                end

                ST_FETCH: begin
                    if (bus.abort) begin
                        state      <= ST_IDLE;
                        word_ready <= 1'b0;
                        busy       <= 1'b0;
                    end else if (bus.word_valid && word_ready) begin
                        // MSB goes straight to the head so the chain shifts the very next cycle.
                        state      <= ST_SHIFT;
                        word_ready <= 1'b0;
                        ccff_se    <= 1'b1;
                        ccff_head  <= bus.word_data[WORD_W-1];
                        shreg      <= {bus.word_data[WORD_W-2:0], 1'b0};
                        bits_left  <= BIT_W'(WORD_W - 1);
                    end
                end

                ST_SHIFT: begin
                    if (bus.abort) begin
                        state     <= ST_IDLE;
                        ccff_se   <= 1'b0;
                        ccff_head <= 1'b0;
                        busy      <= 1'b0;
                    end else begin
                        bit_count <= bit_count + CNT_W'(1);
                        if (last_chain_bit) begin
                            // Any unsent low-order bits of the current word are dropped here.
                            state     <= ST_DONE;
                            ccff_se   <= 1'b0;
                            ccff_head <= 1'b0;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                            isol_n    <= 1'b1;
                        end else if (bits_left == '0) begin
                            state      <= ST_FETCH;
                            ccff_se    <= 1'b0;
                            ccff_head  <= 1'b0;
                            word_ready <= 1'b1;
                        end else begin
                            ccff_head <= shreg[WORD_W-1];
                            shreg     <= {shreg[WORD_W-2:0], 1'b0};
                            bits_left <= bits_left - BIT_W'(1);
                        end
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule
